// File: rtl/demorgan_sweep_ctrl_if.sv
// Bundle between the sweep controller, its test harness and the two De Morgan networks.
// master = the controller; slave = the harness/network side.
interface demorgan_sweep_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             nAandnB;
  logic             nAorB;
  logic             nAornB;
  logic             nAandB;
  logic             A;
  logic             B;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       fail_vec;
  logic [CNT_W-1:0] err_count;

  modport master (
    input  start, abort, nAandnB, nAorB, nAornB, nAandB,
    output A, B, busy, done, pass, fail_vec, err_count
  );

  modport slave (
    output start, abort, nAandnB, nAorB, nAornB, nAandB,
    input  A, B, busy, done, pass, fail_vec, err_count
  );
endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// Sweeps A,B over all four vectors SWEEPS times, samples both De Morgan networks after a
// settle window and accumulates per-vector fail flags, a saturating error count and pass.
module demorgan_sweep_ctrl #(
  parameter int SETTLE = 2,
  parameter int SWEEPS = 1,
  parameter int CNT_W  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  demorgan_sweep_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sweep_q, sweep_d;
  logic [3:0]       settle_q, settle_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err;

  // Both forms must agree with each other and with the golden NOR/NAND of the driven vector.
  assign err = (bus.nAandnB != bus.nAorB) | (bus.nAornB != bus.nAandB) |
               (bus.nAorB != ~(a_q | b_q)) | (bus.nAandB != ~(a_q & b_q));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sweep_d     = sweep_q;
    settle_d    = settle_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          idx_d       = 2'd0;
          sweep_d     = 4'd0;
          settle_d    = 4'd0;
          fail_vec_d  = 4'd0;
          err_count_d = '0;
          pass_d      = 1'b0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else if (settle_q == 4'(SETTLE - 1)) begin
          settle_d = 4'd0;
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          if (err) begin
            fail_vec_d[idx_q] = 1'b1;
            if (!(&err_count_q))
              err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            a_d     = idx_d[1];
            b_d     = idx_d[0];
            state_d = S_DRIVE;
          end else if (sweep_q < 4'(SWEEPS - 1)) begin
            idx_d   = 2'd0;
            sweep_d = sweep_q + 4'd1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            state_d = S_DRIVE;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // A saturated count is never zero, so the final sample is already folded in here.
        pass_d  = (err_count_q == '0);
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      sweep_q     <= 4'd0;
      settle_q    <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sweep_q     <= sweep_d;
      settle_q    <= settle_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (SWEEPS=1 and SWEEPS=15), a run-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_demorgan_sweep_ctrl;
  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demorgan_sweep_ctrl_if #(.CNT_W(4)) bus1 ();
  demorgan_sweep_ctrl_if #(.CNT_W(4)) bus15 ();

  demorgan_sweep_ctrl #(.SETTLE(SETTLE), .SWEEPS(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  demorgan_sweep_ctrl #(.SETTLE(SETTLE), .SWEEPS(15), .CNT_W(4)) dut15 (
    .clk(clk), .rst_n(rst_n), .bus(bus15)
  );

  // fault modes: 0 good, 1 nAorB forced 0, 2 nAandB stuck 1, 3 nAandB stuck 0
  int   fm [2];
  logic start_s [2];
  logic abort_s [2];
  int   sweeps_k [2];

  function automatic logic [3:0] net(int f, logic a, logic b);
    logic nor_o, nand_o;
    nor_o  = (f == 1) ? 1'b0 : ~(a | b);
    nand_o = (f == 2) ? 1'b1 : (f == 3) ? 1'b0 : ~(a & b);
    return {~a & ~b, nor_o, ~a | ~b, nand_o};
  endfunction

  assign bus1.start  = start_s[0];
  assign bus1.abort  = abort_s[0];
  assign bus15.start = start_s[1];
  assign bus15.abort = abort_s[1];
  assign {bus1.nAandnB, bus1.nAorB, bus1.nAornB, bus1.nAandB}     = net(fm[0], bus1.A, bus1.B);
  assign {bus15.nAandnB, bus15.nAorB, bus15.nAornB, bus15.nAandB} = net(fm[1], bus15.A, bus15.B);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Run-level model: position in the run, not controller states.
  bit         m_active [2];
  bit         m_done [2];
  bit         m_pass [2];
  int         m_c [2];
  int         m_errs [2];
  logic [3:0] m_fail [2];

  function automatic bit vec_fails(int f, int v);
    return (f == 1 && v == 0) || (f == 2 && v == 3) || (f == 3 && v != 3);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_done[k] = 0; m_pass[k] = 0;
      m_c[k] = 0; m_errs[k] = 0; m_fail[k] = 4'd0;
    end
  endtask

  task automatic model_step(input int k);
    int v;
    if (m_done[k]) begin
      m_done[k] = 0;
      m_pass[k] = (m_errs[k] == 0);
    end else if (m_active[k]) begin
      if (abort_s[k]) begin
        m_active[k] = 0;
        m_pass[k]   = 0;
      end else begin
        v = (m_c[k] / PER) % 4;
        if ((m_c[k] % PER) == SETTLE && vec_fails(fm[k], v)) begin
          m_fail[k][v] = 1'b1;
          m_errs[k]++;
        end
        m_c[k]++;
        if (m_c[k] == sweeps_k[k] * 4 * PER) begin
          m_active[k] = 0;
          m_done[k]   = 1;
        end
      end
    end else if (start_s[k] && !abort_s[k]) begin
      m_active[k] = 1; m_c[k] = 0; m_errs[k] = 0; m_fail[k] = 4'd0; m_pass[k] = 0;
    end
  endtask

  always @(negedge rst_n) model_reset();
  always @(posedge clk) if (rst_n) for (int k = 0; k < 2; k++) model_step(k);

  task automatic check_inst(input int k, input logic busy, input logic done, input logic a,
                            input logic b, input logic pass, input logic [3:0] fv,
                            input logic [3:0] ec);
    logic [1:0] exp_ab;
    int         sat;
    exp_ab = m_active[k] ? 2'((m_c[k] / PER) % 4) : (m_done[k] ? 2'b11 : 2'b00);
    sat    = (m_errs[k] > 15) ? 15 : m_errs[k];
    chk($sformatf("i%0d_busy", k), 32'(busy), 32'(m_active[k]));
    chk($sformatf("i%0d_done", k), 32'(done), 32'(m_done[k]));
    chk($sformatf("i%0d_AB", k), 32'({a, b}), 32'(exp_ab));
    chk($sformatf("i%0d_pass", k), 32'(pass), 32'(m_pass[k]));
    chk($sformatf("i%0d_fail_vec", k), 32'(fv), 32'(m_fail[k]));
    chk($sformatf("i%0d_err_count", k), 32'(ec), 32'(sat));
  endtask

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    check_inst(0, bus1.busy, bus1.done, bus1.A, bus1.B, bus1.pass, bus1.fail_vec, bus1.err_count);
    check_inst(1, bus15.busy, bus15.done, bus15.A, bus15.B, bus15.pass, bus15.fail_vec,
               bus15.err_count);
  end

  function automatic logic inst_done(int k);
    return (k == 0) ? bus1.done : bus15.done;
  endfunction

  task automatic pulse_start(input int k);
    @(negedge clk); start_s[k] = 1'b1;
    @(negedge clk); start_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int cycles);
    cycles = 0;
    while (cycles < 400 && inst_done(k) !== 1'b1) begin
      @(negedge clk);
      cycles++;
    end
    if (inst_done(k) !== 1'b1) chk($sformatf("i%0d_done_timeout", k), 32'(cycles), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dcount;
    sweeps_k[0] = 1; sweeps_k[1] = 15;
    fm[0] = 0; fm[1] = 0;
    for (int k = 0; k < 2; k++) begin start_s[k] = 1'b0; abort_s[k] = 1'b0; end
    model_reset();
    #12;
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_AB", 32'({bus15.A, bus15.B}), 32'd0);
    chk("rst_err_count", 32'(bus15.err_count), 32'd0);
    chk_en = 1;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start and abort together in IDLE: abort wins
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("start_abort_idle_busy", 32'(bus1.busy), 32'd0);

    // 1: clean run, stepping and latency
    pulse_start(0);
    chk("t1_AB_c0", 32'({bus1.A, bus1.B}), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_AB_c3", 32'({bus1.A, bus1.B}), 32'd1);
    repeat (8) @(negedge clk);
    chk("t1_AB_c11", 32'({bus1.A, bus1.B}), 32'd3);
    wait_done(0, cyc);
    chk("t1_latency", 32'(11 + cyc + 1), 32'd13);
    @(negedge clk);
    chk("t1_pass", 32'(bus1.pass), 32'd1);
    chk("t1_fail_vec", 32'(bus1.fail_vec), 32'd0);

    // 2: nAorB forced low
    fm[0] = 1;
    pulse_start(0); wait_done(0, cyc); @(negedge clk);
    chk("t2_fail_vec", 32'(bus1.fail_vec), 32'b0001);
    chk("t2_err_count", 32'(bus1.err_count), 32'd1);
    chk("t2_pass", 32'(bus1.pass), 32'd0);
    fm[0] = 0;

    // 3: long sweeps with stuck nAandB
    fm[1] = 2;
    pulse_start(1); wait_done(1, cyc); @(negedge clk);
    chk("t3a_err_count", 32'(bus15.err_count), 32'd15);
    chk("t3a_fail_vec", 32'(bus15.fail_vec), 32'b1000);
    fm[1] = 3;
    pulse_start(1); wait_done(1, cyc); @(negedge clk);
    chk("t3b_err_count_sat", 32'(bus15.err_count), 32'd15);
    chk("t3b_fail_vec", 32'(bus15.fail_vec), 32'b0111);
    chk("t3b_pass", 32'(bus15.pass), 32'd0);
    fm[1] = 0;

    // 4: abort in the second SAMPLE cycle (run cycle 5)
    pulse_start(0);
    repeat (5) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk); abort_s[0] = 1'b0;
    chk("t4_busy", 32'(bus1.busy), 32'd0);
    chk("t4_AB", 32'({bus1.A, bus1.B}), 32'd0);
    chk("t4_pass", 32'(bus1.pass), 32'd0);
    repeat (15) @(negedge clk);
    pulse_start(0); wait_done(0, cyc); @(negedge clk);
    chk("t4_rerun_pass", 32'(bus1.pass), 32'd1);

    // 5: start held high, then mid-run pulses
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); wait_done(0, cyc);
    repeat (2) @(negedge clk);
    chk("t5_second_run_busy", 32'(bus1.busy), 32'd1);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b1; @(negedge clk); start_s[0] = 1'b0;
    wait_done(0, cyc);
    repeat (3) @(negedge clk);
    chk("t5_idle_after", 32'(bus1.busy), 32'd0);

    // 6: reset during DRIVE of vector 10
    pulse_start(0);
    repeat (6) @(negedge clk);
    chk("t6_AB_before_rst", 32'({bus1.A, bus1.B}), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_AB", 32'({bus1.A, bus1.B}), 32'd0);
    chk("t6_rst_busy", 32'(bus1.busy), 32'd0);
    chk("t6_rst_err", 32'(bus1.err_count), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus1.done === 1'b1) dcount++;
    end
    chk("t6_no_done", 32'(dcount), 32'd0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
